wrap_event_tracker: RTL and testbench
=====================================

// Module: wrap_event_tracker
// PURPOSE
//   Downstream consumer of the modulo-M summation stage's carry pulses (cop = positive wrap, con = negative wrap).
//   Keeps a saturating signed net wrap count and measures the cycle distance between successive wraps.
//   Classifies the sustained wrap direction with a small FSM.
//   Feeds status/rate monitoring logic; all outputs registered.
// PARAMETERS
//   CW       16  width of signed net wrap count wcnt (two's complement)
//   PW       20  width of period counter / period output (unsigned)
//   DIR_HOLD 4   consecutive same-sign wraps required to declare a direction (>=1)
// PORTS
//   clk        in   1      single clock, all state on rising edge
//   arst       in   1      asynchronous reset, active-low
//   clr        in   1      synchronous clear, same effect as reset
//   cop        in   1      positive-wrap pulse from summation stage
//   con        in   1      negative-wrap pulse from summation stage
//   wcnt       out  CW     signed net wrap count
//   wsat       out  1      sticky: wcnt hit a saturation limit
//   period     out  PW     cycles between the last two wrap events
//   period_vld out  1      1-cycle pulse when period updates
//   dir        out  2      00 IDLE, 01 UP, 10 DOWN (11 unused)
//   dir_chg    out  1      1-cycle pulse on entry to UP or DOWN
// BEHAVIOUR
//   - Reset/clr: wcnt=0, wsat=0, period=0, period_vld=0, dir=IDLE, dir_chg=0, pcnt=0, armed=0, run=0.
//   - clr has priority over any event in the same cycle.
//   - Event definition: ev_p = cop&~con, ev_n = con&~cop, ev = ev_p|ev_n.
//   - cop&con in the same cycle is no event: it touches no state, and pcnt still advances.
//   - Latency: an event sampled at edge n is visible on all outputs after edge n (1 cycle).
//   - wcnt: +1 on ev_p, -1 on ev_n, saturating at +2^(CW-1)-1 / -2^(CW-1).
//   - wsat sets when ev_p arrives while wcnt is at max, or ev_n arrives while wcnt is at min. wcnt is unchanged in that case.
//   - pcnt (internal): +1 per cycle without ev, saturating at 2^PW-1. On ev: pcnt<=1.
//   - Period capture on ev: if armed, period<=pcnt and period_vld=1; otherwise only armed<=1.
//     => events at cycles t and t+3 give period=3. Back-to-back events give period=1.
//   - A saturated pcnt reports period=2^PW-1, meaning ">= max".
//   - Direction FSM (run = count of consecutive same-sign events, saturating at DIR_HOLD, with a sign flag):
//       IDLE: run reaches DIR_HOLD with + sign -> UP; with - sign -> DOWN; dir_chg=1.
//       UP:   DIR_HOLD consecutive ev_n -> DOWN, dir_chg=1. ev_p keeps UP.
//       DOWN: mirror of UP.
//       Opposite-sign event: run<=1 with the new sign. Same sign: run+1.
//       Any state: pcnt saturates (no wrap for 2^PW-1 cycles) -> IDLE, run=0, no dir_chg.
//       DIR_HOLD=1: first event sets the direction immediately.
//   - arst mid-operation: all outputs take reset values at once. Pulses drop in the same cycle.
// STRUCTURE
//   - summation_pkg (shared): dir encodings DIR_IDLE/DIR_UP/DIR_DOWN, event decode helper.
//   - Sub-module event_period_meter: pcnt, armed, period, period_vld, pcnt_sat output.
//     Parameter PW; inputs clk, arst, clr, ev.
//   - Top level holds: sat counter, direction FSM (3-state, registered), run counter.
// TESTING
//   1 Reset: arst=0 -> all outputs 0, dir=00. Release, no events for 10 cycles -> still 0.
//   2 Period: cop at cycles 5, 8, 9 -> first event no vld. Then period=3 with vld, then period=1 with vld.
//     wcnt=3 and dir=UP with dir_chg (DIR_HOLD=3 override).
//   3 Direction: DIR_HOLD=4; cop x4 -> UP+dir_chg.
//     con,cop,con x4 -> stays UP until the 4th consecutive con, then DOWN+dir_chg. wcnt=+4-1+1-4=0.
//   4 Saturation: CW=4; 9 cops -> wcnt=7, wsat=1. Then con x16 -> wcnt=-8, wsat remains 1.
//   5 Conflict/clr: cop&con together -> no change in wcnt/run/period. clr with cop -> reset values, cop ignored.
//   6 Timeout: PW=4, dir=UP, no events 15 cycles -> dir=IDLE, no dir_chg.
//     Next two cops 3 cycles apart -> period=15 then period=3.

Source files
------------

// File: rtl/summation_pkg.sv
// Shared definitions for the modulo-M summation stage and its consumers:
// wrap-direction encodings and the decode of the raw carry pulse pair.
package summation_pkg;

  typedef enum logic [1:0] {
    DIR_IDLE = 2'b00,
    DIR_UP   = 2'b01,
    DIR_DOWN = 2'b10
  } dir_e;

  typedef struct packed {
    logic ev_p;
    logic ev_n;
    logic ev;
  } ev_t;

  // cop and con together cancel out and are treated as no wrap at all.
  function automatic ev_t decode_ev(input logic cop, input logic con);
    ev_t r;
    r.ev_p = cop & ~con;
    r.ev_n = con & ~cop;
    r.ev   = r.ev_p | r.ev_n;
    return r;
  endfunction

endpackage

// File: rtl/event_period_meter.sv
// Measures the number of cycles between successive wrap events.
// The first event after reset/clear only arms the meter; every later event
// reports the distance to its predecessor. A saturated count means ">= max".
module event_period_meter #(
  parameter int PW = 20
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          clr,
  input  logic          ev,
  output logic [PW-1:0] period,
  output logic          period_vld,
  output logic          pcnt_sat
);

  localparam logic [PW-1:0] PCNT_MAX  = {PW{1'b1}};
  localparam logic [PW-1:0] PCNT_ONE  = PW'(1'b1);
  localparam logic [PW-1:0] PCNT_ZERO = {PW{1'b0}};

  logic [PW-1:0] pcnt_r;
  logic          armed_r;
  logic [PW-1:0] period_r;
  logic          period_vld_r;

  // Cycle counter restarts at 1 on each event; period is captured once armed.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      pcnt_r       <= PCNT_ZERO;
      armed_r      <= 1'b0;
      period_r     <= PCNT_ZERO;
      period_vld_r <= 1'b0;
    end else if (clr) begin
      pcnt_r       <= PCNT_ZERO;
      armed_r      <= 1'b0;
      period_r     <= PCNT_ZERO;
      period_vld_r <= 1'b0;
    end else if (ev) begin
      pcnt_r <= PCNT_ONE;
      if (armed_r) begin
        period_r     <= pcnt_r;
        period_vld_r <= 1'b1;
      end else begin
        armed_r      <= 1'b1;
        period_vld_r <= 1'b0;
      end
    end else begin
      if (pcnt_r != PCNT_MAX) begin
        pcnt_r <= pcnt_r + PCNT_ONE;
      end else begin
        pcnt_r <= pcnt_r;
      end
      period_vld_r <= 1'b0;
    end
  end

  assign period     = period_r;
  assign period_vld = period_vld_r;
  assign pcnt_sat   = (pcnt_r == PCNT_MAX);

endmodule

// File: rtl/wrap_event_tracker.sv
// Consumes the positive/negative wrap pulses of the summation stage:
// keeps a saturating signed net wrap count, measures the wrap period and
// classifies the sustained wrap direction. All outputs are registered.
module wrap_event_tracker
  import summation_pkg::*;
#(
  parameter int CW       = 16,
  parameter int PW       = 20,
  parameter int DIR_HOLD = 4
) (
  input  logic          clk,
  input  logic          arst,
  input  logic          clr,
  input  logic          cop,
  input  logic          con,
  output logic [CW-1:0] wcnt,
  output logic          wsat,
  output logic [PW-1:0] period,
  output logic          period_vld,
  output logic [1:0]    dir,
  output logic          dir_chg
);

  localparam int RW = $clog2(DIR_HOLD + 1);
  localparam logic [RW-1:0] RUN_HOLD = RW'(DIR_HOLD);
  localparam logic [RW-1:0] RUN_ONE  = RW'(1'b1);
  localparam logic [RW-1:0] RUN_ZERO = {RW{1'b0}};

  localparam logic [CW-1:0] WCNT_MAX  = {1'b0, {(CW-1){1'b1}}};
  localparam logic [CW-1:0] WCNT_MIN  = {1'b1, {(CW-1){1'b0}}};
  localparam logic [CW-1:0] WCNT_ONE  = CW'(1'b1);
  localparam logic [CW-1:0] WCNT_ZERO = {CW{1'b0}};

  ev_t           ev_s;
  logic          pcnt_sat_s;
  logic [CW-1:0] wcnt_r;
  logic          wsat_r;
  dir_e          dir_r;
  logic          dir_chg_r;
  logic [RW-1:0] run_r;
  logic          run_neg_r;
  logic [RW-1:0] run_nxt_s;
  logic          run_neg_nxt_s;
  logic          hold_s;

  assign ev_s = decode_ev(cop, con);

  event_period_meter #(
    .PW (PW)
  ) u_meter (
    .clk        (clk),
    .arst       (arst),
    .clr        (clr),
    .ev         (ev_s.ev),
    .period     (period),
    .period_vld (period_vld),
    .pcnt_sat   (pcnt_sat_s)
  );

  // Saturating net wrap count; a blocked step sets the sticky flag.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      wcnt_r <= WCNT_ZERO;
      wsat_r <= 1'b0;
    end else if (clr) begin
      wcnt_r <= WCNT_ZERO;
      wsat_r <= 1'b0;
    end else if (ev_s.ev_p) begin
      if (wcnt_r == WCNT_MAX) begin
        wsat_r <= 1'b1;
      end else begin
        wcnt_r <= wcnt_r + WCNT_ONE;
      end
    end else if (ev_s.ev_n) begin
      if (wcnt_r == WCNT_MIN) begin
        wsat_r <= 1'b1;
      end else begin
        wcnt_r <= wcnt_r - WCNT_ONE;
      end
    end else begin
      wcnt_r <= wcnt_r;
    end
  end

  // Next value of the same-sign run: restart on a sign change, else count up to the hold.
  always_comb begin
    run_nxt_s     = run_r;
    run_neg_nxt_s = run_neg_r;
    if (ev_s.ev) begin
      if ((run_r == RUN_ZERO) || (run_neg_r != ev_s.ev_n)) begin
        run_nxt_s     = RUN_ONE;
        run_neg_nxt_s = ev_s.ev_n;
      end else if (run_r != RUN_HOLD) begin
        run_nxt_s = run_r + RUN_ONE;
      end else begin
        run_nxt_s = run_r;
      end
    end else begin
      run_nxt_s     = run_r;
      run_neg_nxt_s = run_neg_r;
    end
  end

  assign hold_s = ev_s.ev && (run_nxt_s == RUN_HOLD);

  // Direction FSM with run tracking; a long silence (period counter saturated) drops to IDLE.
  always_ff @(posedge clk or negedge arst) begin
    if (!arst) begin
      dir_r     <= DIR_IDLE;
      dir_chg_r <= 1'b0;
      run_r     <= RUN_ZERO;
      run_neg_r <= 1'b0;
    end else if (clr) begin
      dir_r     <= DIR_IDLE;
      dir_chg_r <= 1'b0;
      run_r     <= RUN_ZERO;
      run_neg_r <= 1'b0;
    end else if (ev_s.ev) begin
      run_r     <= run_nxt_s;
      run_neg_r <= run_neg_nxt_s;
      case (dir_r)
        DIR_IDLE: begin
          if (hold_s) begin
            dir_r     <= run_neg_nxt_s ? DIR_DOWN : DIR_UP;
            dir_chg_r <= 1'b1;
          end else begin
            dir_chg_r <= 1'b0;
          end
        end
        DIR_UP: begin
          if (hold_s && run_neg_nxt_s) begin
            dir_r     <= DIR_DOWN;
            dir_chg_r <= 1'b1;
          end else begin
            dir_chg_r <= 1'b0;
          end
        end
        DIR_DOWN: begin
          if (hold_s && !run_neg_nxt_s) begin
            dir_r     <= DIR_UP;
            dir_chg_r <= 1'b1;
          end else begin
            dir_chg_r <= 1'b0;
          end
        end
        default: begin
          dir_r     <= DIR_IDLE;
          dir_chg_r <= 1'b0;
        end
      endcase
    end else if (pcnt_sat_s) begin
      dir_r     <= DIR_IDLE;
      dir_chg_r <= 1'b0;
      run_r     <= RUN_ZERO;
      run_neg_r <= 1'b0;
    end else begin
      dir_chg_r <= 1'b0;
    end
  end

  assign wcnt    = wcnt_r;
  assign wsat    = wsat_r;
  assign dir     = dir_r;
  assign dir_chg = dir_chg_r;

endmodule

// File: tb/tb_wrap_event_tracker.sv
// Directed bench for wrap_event_tracker. Two instances share the stimulus:
// dut_a (CW=16, PW=20, DIR_HOLD=3) and dut_b (CW=4, PW=4, DIR_HOLD=4).
module tb_wrap_event_tracker;

  logic        clk  = 1'b0;
  logic        arst = 1'b0;
  logic        clr  = 1'b0;
  logic        cop  = 1'b0;
  logic        con  = 1'b0;

  logic [15:0] wcnt_a;
  logic        wsat_a;
  logic [19:0] period_a;
  logic        vld_a;
  logic [1:0]  dir_a;
  logic        chg_a;

  logic [3:0]  wcnt_b;
  logic        wsat_b;
  logic [3:0]  period_b;
  logic        vld_b;
  logic [1:0]  dir_b;
  logic        chg_b;

  int checks   = 0;
  int failures = 0;

  typedef struct {
    logic       cop;
    logic       con;
    logic       clr;
    int         wcnt;
    logic       wsat;
    int         period;
    logic       vld;
    logic [1:0] dir;
    logic       chg;
  } vec_t;

  vec_t tbl[16];

  wrap_event_tracker #(.CW(16), .PW(20), .DIR_HOLD(3)) dut_a (
    .clk(clk), .arst(arst), .clr(clr), .cop(cop), .con(con),
    .wcnt(wcnt_a), .wsat(wsat_a), .period(period_a), .period_vld(vld_a),
    .dir(dir_a), .dir_chg(chg_a)
  );

  wrap_event_tracker #(.CW(4), .PW(4), .DIR_HOLD(4)) dut_b (
    .clk(clk), .arst(arst), .clr(clr), .cop(cop), .con(con),
    .wcnt(wcnt_b), .wsat(wsat_b), .period(period_b), .period_vld(vld_b),
    .dir(dir_b), .dir_chg(chg_b)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  task automatic chk_a(input string tag, input int w, input logic s, input int p,
                       input logic v, input logic [1:0] d, input logic c);
    chk({tag, ".a.wcnt"},   int'($signed(wcnt_a)), w);
    chk({tag, ".a.wsat"},   int'(wsat_a), int'(s));
    chk({tag, ".a.period"}, int'(period_a), p);
    chk({tag, ".a.vld"},    int'(vld_a), int'(v));
    chk({tag, ".a.dir"},    int'(dir_a), int'(d));
    chk({tag, ".a.chg"},    int'(chg_a), int'(c));
  endtask

  task automatic chk_b(input string tag, input int w, input logic s, input int p,
                       input logic v, input logic [1:0] d, input logic c);
    chk({tag, ".b.wcnt"},   int'($signed(wcnt_b)), w);
    chk({tag, ".b.wsat"},   int'(wsat_b), int'(s));
    chk({tag, ".b.period"}, int'(period_b), p);
    chk({tag, ".b.vld"},    int'(vld_b), int'(v));
    chk({tag, ".b.dir"},    int'(dir_b), int'(d));
    chk({tag, ".b.chg"},    int'(chg_b), int'(c));
  endtask

  // Drive inputs away from the active edge, then sample just after it.
  task automatic step(input logic c_p, input logic c_n, input logic c_clr);
    @(negedge clk);
    cop = c_p;
    con = c_n;
    clr = c_clr;
    @(posedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b0, 1'b0);
  endtask

  // Watchdog so the run always terminates.
  initial begin
    #200000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    // dut_b after clr: up-run, direction flip, conflicts, clr beats cop.
    //            cop   con   clr   wcnt wsat  per vld   dir    chg
    tbl[0]  = '{1'b1, 1'b0, 1'b0,  1, 1'b0, 0, 1'b0, 2'b00, 1'b0};
    tbl[1]  = '{1'b1, 1'b0, 1'b0,  2, 1'b0, 1, 1'b1, 2'b00, 1'b0};
    tbl[2]  = '{1'b1, 1'b0, 1'b0,  3, 1'b0, 1, 1'b1, 2'b00, 1'b0};
    tbl[3]  = '{1'b1, 1'b0, 1'b0,  4, 1'b0, 1, 1'b1, 2'b01, 1'b1};
    tbl[4]  = '{1'b0, 1'b0, 1'b0,  4, 1'b0, 1, 1'b0, 2'b01, 1'b0};
    tbl[5]  = '{1'b0, 1'b1, 1'b0,  3, 1'b0, 2, 1'b1, 2'b01, 1'b0};
    tbl[6]  = '{1'b1, 1'b0, 1'b0,  4, 1'b0, 1, 1'b1, 2'b01, 1'b0};
    tbl[7]  = '{1'b0, 1'b1, 1'b0,  3, 1'b0, 1, 1'b1, 2'b01, 1'b0};
    tbl[8]  = '{1'b0, 1'b1, 1'b0,  2, 1'b0, 1, 1'b1, 2'b01, 1'b0};
    tbl[9]  = '{1'b0, 1'b1, 1'b0,  1, 1'b0, 1, 1'b1, 2'b01, 1'b0};
    tbl[10] = '{1'b0, 1'b1, 1'b0,  0, 1'b0, 1, 1'b1, 2'b10, 1'b1};
    tbl[11] = '{1'b1, 1'b1, 1'b0,  0, 1'b0, 1, 1'b0, 2'b10, 1'b0};
    tbl[12] = '{1'b0, 1'b1, 1'b0, -1, 1'b0, 2, 1'b1, 2'b10, 1'b0};
    tbl[13] = '{1'b1, 1'b1, 1'b0, -1, 1'b0, 2, 1'b0, 2'b10, 1'b0};
    tbl[14] = '{1'b1, 1'b0, 1'b0,  0, 1'b0, 2, 1'b1, 2'b10, 1'b0};
    tbl[15] = '{1'b1, 1'b0, 1'b1,  0, 1'b0, 0, 1'b0, 2'b00, 1'b0};

    // Reset state, then quiet operation keeps everything at zero.
    #22;
    chk_a("reset", 0, 1'b0, 0, 1'b0, 2'b00, 1'b0);
    chk_b("reset", 0, 1'b0, 0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    arst = 1'b1;
    idle(10);
    chk_a("quiet", 0, 1'b0, 0, 1'b0, 2'b00, 1'b0);
    chk_b("quiet", 0, 1'b0, 0, 1'b0, 2'b00, 1'b0);

    // Period measurement on dut_a: events at cycles 5, 8, 9.
    step(1'b0, 1'b0, 1'b1);
    idle(4);
    step(1'b1, 1'b0, 1'b0);
    chk_a("per.first", 1, 1'b0, 0, 1'b0, 2'b00, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    chk_a("per.three", 2, 1'b0, 3, 1'b1, 2'b00, 1'b0);
    step(1'b1, 1'b0, 1'b0);
    chk_a("per.one", 3, 1'b0, 1, 1'b1, 2'b01, 1'b1);

    // Async reset mid-operation: pulses and state drop without a clock edge.
    #2;
    cop  = 1'b0;
    arst = 1'b0;
    #1;
    chk_a("arst.mid", 0, 1'b0, 0, 1'b0, 2'b00, 1'b0);
    chk_b("arst.mid", 0, 1'b0, 0, 1'b0, 2'b00, 1'b0);
    @(negedge clk);
    arst = 1'b1;

    // Table-driven sequence on dut_b.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 16; i++) begin
      step(tbl[i].cop, tbl[i].con, tbl[i].clr);
      chk_b($sformatf("tbl%0d", i), tbl[i].wcnt, tbl[i].wsat, tbl[i].period,
            tbl[i].vld, tbl[i].dir, tbl[i].chg);
    end

    // Saturation on dut_b (CW=4).
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 7; i++) step(1'b1, 1'b0, 1'b0);
    chk("sat.at_max.wcnt", int'($signed(wcnt_b)), 7);
    chk("sat.at_max.wsat", int'(wsat_b), 0);
    for (int i = 0; i < 2; i++) step(1'b1, 1'b0, 1'b0);
    chk("sat.pos.wcnt", int'($signed(wcnt_b)), 7);
    chk("sat.pos.wsat", int'(wsat_b), 1);
    chk("sat.pos.dir", int'(dir_b), 1);
    for (int i = 0; i < 16; i++) step(1'b0, 1'b1, 1'b0);
    chk("sat.neg.wcnt", int'($signed(wcnt_b)), -8);
    chk("sat.neg.wsat", int'(wsat_b), 1);
    chk("sat.neg.dir", int'(dir_b), 2);

    // Timeout on dut_b (PW=4): 15 silent cycles drop UP to IDLE.
    step(1'b0, 1'b0, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 1'b0);
    chk_b("to.up", 4, 1'b0, 1, 1'b1, 2'b01, 1'b1);
    idle(14);
    chk("to.before.dir", int'(dir_b), 1);
    idle(1);
    chk("to.idle.dir", int'(dir_b), 0);
    chk("to.idle.chg", int'(chg_b), 0);
    step(1'b1, 1'b0, 1'b0);
    chk_b("to.maxper", 5, 1'b0, 15, 1'b1, 2'b00, 1'b0);
    idle(2);
    step(1'b1, 1'b0, 1'b0);
    chk_b("to.per3", 6, 1'b0, 3, 1'b1, 2'b00, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
